// File: rtl/phase_sequencer.sv
// phase_sequencer: five-phase clock generator for the multicycle SIMPLE processor.
// One instruction spans 10*HALF cycles; supports start, single-step pause and sticky halt.
module phase_sequencer #(
    parameter int HALF        = 1,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   haltin,
    input  logic                   stepmode,
    output logic                   clockp1,
    output logic                   clockp2,
    output logic                   clockp3,
    output logic                   clockp4,
    output logic                   clockp5,
    output logic [2:0]             phase,
    output logic                   running,
    output logic                   halted,
    output logic [COUNT_WIDTH-1:0] instcount
);

    localparam int SUB_W = $clog2(2 * HALF);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(2 * HALF - 1);
    localparam logic [SUB_W-1:0] SUB_HIGH = SUB_W'(HALF);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSE  = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    logic [1:0]             state;
    logic [1:0]             nxt_state;
    logic [SUB_W-1:0]       sub;
    logic [SUB_W-1:0]       nxt_sub;
    logic [2:0]             nxt_phase;
    logic [COUNT_WIDTH-1:0] nxt_count;
    logic                   strobe_on;

    always_comb begin
        nxt_state = state;
        nxt_sub   = sub;
        nxt_phase = phase;
        nxt_count = instcount;
        case (state)
            S_IDLE, S_PAUSE: begin
                if (start) begin
                    nxt_state = S_RUN;
                    nxt_phase = 3'd1;
                    nxt_sub   = '0;
                end
            end
            S_RUN: begin
                if (sub == SUB_LAST) begin
                    nxt_sub = '0;
                    if (phase == 3'd5) begin
                        // End of write-back: retire, then halt beats step beats continue.
                        nxt_count = instcount + COUNT_WIDTH'(1);
                        if (haltin) begin
                            nxt_state = S_HALTED;
                            nxt_phase = 3'd0;
                        end else if (stepmode) begin
                            nxt_state = S_PAUSE;
                            nxt_phase = 3'd0;
                        end else begin
                            nxt_phase = 3'd1;
                        end
                    end else begin
                        nxt_phase = phase + 3'd1;
                    end
                end else begin
                    nxt_sub = sub + SUB_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Strobes are decoded from the next state so every output leaves a flop.
    assign strobe_on = (nxt_state == S_RUN) && (nxt_sub < SUB_HIGH);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            sub       <= '0;
            phase     <= 3'd0;
            instcount <= '0;
            running   <= 1'b0;
            halted    <= 1'b0;
            clockp1   <= 1'b0;
            clockp2   <= 1'b0;
            clockp3   <= 1'b0;
            clockp4   <= 1'b0;
            clockp5   <= 1'b0;
        end else begin
            state     <= nxt_state;
            sub       <= nxt_sub;
            phase     <= nxt_phase;
            instcount <= nxt_count;
            running   <= (nxt_state == S_RUN);
            halted    <= (nxt_state == S_HALTED);
            clockp1   <= strobe_on && (nxt_phase == 3'd1);
            clockp2   <= strobe_on && (nxt_phase == 3'd2);
            clockp3   <= strobe_on && (nxt_phase == 3'd3);
            clockp4   <= strobe_on && (nxt_phase == 3'd4);
            clockp5   <= strobe_on && (nxt_phase == 3'd5);
        end
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: two instances (HALF=1/16-bit count, HALF=3/4-bit count)
// checked every cycle against an instruction-cycle model, plus directed literal checks.
module tb_phase_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic haltin = 1'b0;
    logic stepmode = 1'b0;

    logic a_p1, a_p2, a_p3, a_p4, a_p5, a_run, a_hlt;
    logic [2:0]  a_ph;
    logic [15:0] a_cnt;
    logic b_p1, b_p2, b_p3, b_p4, b_p5, b_run, b_hlt;
    logic [2:0]  b_ph;
    logic [3:0]  b_cnt;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    always #5 clock = ~clock;

    phase_sequencer #(.HALF(1), .COUNT_WIDTH(16)) dut_a (
        .clock(clock), .reset(reset), .start(start), .haltin(haltin), .stepmode(stepmode),
        .clockp1(a_p1), .clockp2(a_p2), .clockp3(a_p3), .clockp4(a_p4), .clockp5(a_p5),
        .phase(a_ph), .running(a_run), .halted(a_hlt), .instcount(a_cnt));

    phase_sequencer #(.HALF(3), .COUNT_WIDTH(4)) dut_b (
        .clock(clock), .reset(reset), .start(start), .haltin(haltin), .stepmode(stepmode),
        .clockp1(b_p1), .clockp2(b_p2), .clockp3(b_p3), .clockp4(b_p4), .clockp5(b_p5),
        .phase(b_ph), .running(b_run), .halted(b_hlt), .instcount(b_cnt));

    logic [4:0]  clk_v [2];
    logic [2:0]  ph_v  [2];
    logic        run_v [2];
    logic        hlt_v [2];
    logic [15:0] cnt_v [2];

    assign clk_v[0] = {a_p5, a_p4, a_p3, a_p2, a_p1};
    assign clk_v[1] = {b_p5, b_p4, b_p3, b_p2, b_p1};
    assign ph_v[0]  = a_ph;
    assign ph_v[1]  = b_ph;
    assign run_v[0] = a_run;
    assign run_v[1] = b_run;
    assign hlt_v[0] = a_hlt;
    assign hlt_v[1] = b_hlt;
    assign cnt_v[0] = a_cnt;
    assign cnt_v[1] = {12'd0, b_cnt};

    // Model: mode 0 idle, 1 run, 2 pause, 3 halted; mt = cycle index inside the instruction.
    int mst  [2];
    int mt   [2];
    int mcnt [2];

    function automatic int half_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int mod_of(input int i);
        return (i == 0) ? 65536 : 16;
    endfunction

    always @(posedge clock or negedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                mst[i]  <= 0;
                mt[i]   <= 0;
                mcnt[i] <= 0;
            end else begin
                case (mst[i])
                    0, 2: if (start) begin
                        mst[i] <= 1;
                        mt[i]  <= 0;
                    end
                    1: if (mt[i] == 10 * half_of(i) - 1) begin
                        mcnt[i] <= (mcnt[i] + 1) % mod_of(i);
                        mt[i]   <= 0;
                        if (haltin) mst[i] <= 3;
                        else if (stepmode) mst[i] <= 2;
                    end else begin
                        mt[i] <= mt[i] + 1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                int h;
                int ph;
                logic [4:0] ecl;
                h   = half_of(i);
                ph  = (mst[i] == 1) ? mt[i] / (2 * h) + 1 : 0;
                ecl = (mst[i] == 1 && (mt[i] % (2 * h)) < h) ? 5'(1 << (ph - 1)) : 5'd0;
                checks++;
                if (clk_v[i] !== ecl || ph_v[i] !== 3'(ph) || run_v[i] !== (mst[i] == 1) ||
                    hlt_v[i] !== (mst[i] == 3) || cnt_v[i] !== 16'(mcnt[i])) begin
                    errors++;
                    $display("FAIL cycle dut%0d t=%0t got clk=%b ph=%0d run=%b hlt=%b cnt=%0d need clk=%b ph=%0d run=%0d hlt=%0d cnt=%0d",
                             i, $time, clk_v[i], ph_v[i], run_v[i], hlt_v[i], cnt_v[i],
                             ecl, ph, (mst[i] == 1), (mst[i] == 3), mcnt[i]);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic lit(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    logic [4:0] exp_tab [10];

    initial begin
        exp_tab = '{5'd1, 5'd0, 5'd2, 5'd0, 5'd4, 5'd0, 5'd8, 5'd0, 5'd16, 5'd0};
        tick(1);
        chk_en = 1'b1;
        lit("reset_count", a_cnt, 0);
        lit("reset_phase", a_ph, 0);
        tick(1);
        reset = 1'b1;
        tick(1);

        // First instruction: strobes at relative cycles 0,2,4,6,8.
        pulse_start();
        for (int j = 0; j < 10; j++) begin
            lit("first_strobe", {a_p5, a_p4, a_p3, a_p2, a_p1}, exp_tab[j]);
            tick(1);
        end
        lit("first_count", a_cnt, 1);
        lit("next_p1", a_p1, 1);
        tick(20);
        lit("free_count", a_cnt, 3);
        lit("free_running", a_run, 1);

        // Asynchronous reset in the middle of phase 3.
        tick(4);
        lit("pre_reset_p3", a_p3, 1);
        reset = 1'b0;
        #1;
        lit("async_p3", a_p3, 0);
        lit("async_phase", a_ph, 0);
        lit("async_count", a_cnt, 0);
        tick(2);
        reset = 1'b1;
        tick(1);

        // Single step.
        stepmode = 1'b1;
        pulse_start();
        tick(10);
        lit("step_running", a_run, 0);
        lit("step_phase", a_ph, 0);
        lit("step_count", a_cnt, 1);
        tick(20);
        lit("step_idle_strobes", {a_p5, a_p4, a_p3, a_p2, a_p1}, 0);
        lit("step_hold_count", a_cnt, 1);
        pulse_start();
        lit("resume_p1", a_p1, 1);
        tick(10);
        lit("step2_count", a_cnt, 2);
        lit("step2_running", a_run, 0);

        // Halt raised in phase 2 wins over step.
        pulse_start();
        tick(2);
        haltin = 1'b1;
        tick(8);
        lit("halt_flag", a_hlt, 1);
        lit("halt_count", a_cnt, 3);
        lit("halt_running", a_run, 0);
        haltin = 1'b0;
        repeat (3) begin
            pulse_start();
            tick(2);
        end
        lit("halt_sticky", a_hlt, 1);
        lit("halt_hold_count", a_cnt, 3);
        lit("halt_phase", a_ph, 0);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(1);
        lit("halt_cleared", a_hlt, 0);

        // haltin away from the sampling point is ignored.
        stepmode = 1'b0;
        pulse_start();
        tick(4);
        haltin = 1'b1;
        tick(2);
        haltin = 1'b0;
        tick(4);
        lit("nohalt_p1", a_p1, 1);
        lit("nohalt_flag", a_hlt, 0);
        lit("nohalt_count", a_cnt, 1);

        // Stretched phases and 4-bit counter wrap.
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(1);
        pulse_start();
        lit("h3_p1_first", b_p1, 1);
        tick(2);
        lit("h3_p1_last", b_p1, 1);
        tick(1);
        lit("h3_p1_low", b_p1, 0);
        tick(3);
        lit("h3_p2_high", b_p2, 1);
        tick(24);
        lit("h3_count1", b_cnt, 1);
        tick(480);
        lit("wrap_count", b_cnt, 1);
        lit("wrap_running", b_run, 1);
        lit("h1_long_count", a_cnt, 51);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
